// File: rtl/capture_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : capture_mem_pkg - shared line geometry, arbiter states, line record
// Rev    : 1.0
// ============================================================================
package capture_mem_pkg;

    localparam int LINE_WIDTH          = 128;
    localparam int PACKETS_PER_LINE    = 4;
    localparam int MEM_ADDR_WIDTH      = 27;
    localparam int PACKET_WIDTH        = LINE_WIDTH / PACKETS_PER_LINE;
    localparam int SAMPLE_NUMBER_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_CMD = 2'd1,
        ST_RD_CMD = 2'd2
    } arbState_t;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0]   addr;
        logic [LINE_WIDTH-1:0]       data;
        logic [PACKETS_PER_LINE-1:0] mask;
    } line_t;

endpackage
`default_nettype wire

// File: rtl/capture_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : capture_mem_arbiter_if - capture, readback and memory command bus
// Rev    : 1.0
// ============================================================================
interface capture_mem_arbiter_if;
    import capture_mem_pkg::*;

    logic [PACKET_WIDTH-1:0]        sample_packet;
    logic                           write_enable;
    logic [SAMPLE_NUMBER_WIDTH-1:0] sample_number;
    logic                           flush;
    logic                           page_full;
    logic                           flush_done;
    logic                           overflow;
    logic                           read_req;
    logic [MEM_ADDR_WIDTH-1:0]      read_sample_address;
    logic                           read_allowed;
    logic                           mem_cmd_valid;
    logic                           mem_cmd_ready;
    logic                           mem_cmd_write;
    logic [MEM_ADDR_WIDTH-1:0]      mem_cmd_addr;
    logic [LINE_WIDTH-1:0]          mem_wdata;
    logic [PACKETS_PER_LINE-1:0]    mem_wmask;

    // master = the arbiter, slave = capture core / readback / memory side
    modport master (
        input  sample_packet, write_enable, sample_number, flush,
               read_req, read_sample_address, mem_cmd_ready,
        output page_full, flush_done, overflow, read_allowed,
               mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output sample_packet, write_enable, sample_number, flush,
               read_req, read_sample_address, mem_cmd_ready,
        input  page_full, flush_done, overflow, read_allowed,
               mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wdata, mem_wmask
    );

endinterface
`default_nettype wire

// File: rtl/sample_line_packer.sv
`default_nettype none
// ============================================================================
// Module : sample_line_packer - gathers packets into one line, pushes it out
// Rev    : 1.0
// ============================================================================
module sample_line_packer
    import capture_mem_pkg::*;
#(
    parameter int SAMPLE_PACKET_WIDTH = 32
) (
    input  wire logic                           clk,
    input  wire logic                           reset_n,
    input  wire logic [SAMPLE_PACKET_WIDTH-1:0] i_samplePacket,
    input  wire logic                           i_writeEnable,
    input  wire logic [SAMPLE_NUMBER_WIDTH-1:0] i_sampleNumber,
    input  wire logic                           i_flush,
    output logic                                o_push,
    output line_t                               o_pushLine,
    output logic                                o_empty
);

    line_t                     r_line;
    logic                      r_flushPend;
    line_t                     w_next;
    logic [1:0]                w_slot;
    logic [MEM_ADDR_WIDTH-1:0] w_addr;
    logic                      w_held;
    logic                      w_push;
    logic                      w_unusedSampleHi;

    assign w_unusedSampleHi = ^i_sampleNumber[SAMPLE_NUMBER_WIDTH-1:MEM_ADDR_WIDTH+2];

    // A held line leaves one cycle after it completes, was flushed, or a packet
    // for another line arrives; the arriving packet then opens the fresh line.
    always_comb begin
        w_slot = i_sampleNumber[1:0];
        w_addr = i_sampleNumber[MEM_ADDR_WIDTH+1:2];
        w_held = |r_line.mask;
        w_push = w_held && (r_line.mask[PACKETS_PER_LINE-1] || r_flushPend ||
                            (i_writeEnable && (w_addr != r_line.addr)));
        if (w_push) begin
            w_next = '0;
        end else begin
            w_next = r_line;
        end
        if (i_writeEnable) begin
            w_next.addr = w_addr;
            for (int s = 0; s < PACKETS_PER_LINE; s++) begin
                if (w_slot == 2'(s)) begin
                    w_next.data[s*SAMPLE_PACKET_WIDTH +: SAMPLE_PACKET_WIDTH] = i_samplePacket;
                    w_next.mask[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line      <= '0;
            r_flushPend <= 1'b0;
        end else begin
            r_line      <= w_next;
            r_flushPend <= i_flush && (|w_next.mask);
        end
    end

    assign o_push     = w_push;
    assign o_pushLine = r_line;
    assign o_empty    = !w_held;

endmodule
`default_nettype wire

// File: rtl/capture_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : capture_mem_arbiter - line FIFO plus write/read command arbiter
// Rev    : 1.0
// ============================================================================
module capture_mem_arbiter
    import capture_mem_pkg::*;
#(
    parameter int SAMPLE_PACKET_WIDTH = 32,
    parameter int LINE_FIFO_DEPTH     = 4,
    parameter int WR_URGENT           = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    capture_mem_arbiter_if.master bus
);

    localparam int                 c_PTR_W    = $clog2(LINE_FIFO_DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(LINE_FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_PF_LEVEL = c_CNT_W'(LINE_FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_URGENT   = c_CNT_W'(WR_URGENT);

    logic                      w_push;
    line_t                     w_pushLine;
    logic                      w_packerEmpty;
    line_t                     r_fifo [LINE_FIFO_DEPTH];
    logic [c_PTR_W-1:0]        r_wrPtr;
    logic [c_PTR_W-1:0]        r_rdPtr;
    logic [c_CNT_W-1:0]        r_count;
    logic                      r_overflow;
    logic                      r_pageFull;
    logic                      r_flushWait;
    arbState_t                 r_state;
    arbState_t                 w_nextState;
    logic                      r_lastWrite;
    logic [MEM_ADDR_WIDTH-1:0] r_rdAddr;
    line_t                     w_head;
    logic                      w_fifoFull;
    logic                      w_fifoWrite;
    logic                      w_pop;
    logic                      w_wrPending;
    logic                      w_flushDone;

    sample_line_packer #(
        .SAMPLE_PACKET_WIDTH(SAMPLE_PACKET_WIDTH)
    ) u_packer (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_samplePacket (bus.sample_packet),
        .i_writeEnable  (bus.write_enable),
        .i_sampleNumber (bus.sample_number),
        .i_flush        (bus.flush),
        .o_push         (w_push),
        .o_pushLine     (w_pushLine),
        .o_empty        (w_packerEmpty)
    );

    assign w_head      = r_fifo[r_rdPtr];
    assign w_fifoFull  = (r_count == c_DEPTH);
    assign w_fifoWrite = w_push && !w_fifoFull;
    assign w_pop       = (r_state == ST_WR_CMD) && bus.mem_cmd_ready;
    assign w_wrPending = (r_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_pageFull <= 1'b0;
            for (int i = 0; i < LINE_FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_fifoWrite) begin
                r_fifo[r_wrPtr] <= w_pushLine;
                r_wrPtr         <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_fifoWrite, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_push && w_fifoFull) begin
                r_overflow <= 1'b1;
            end
            // Raised one entry early so packets already in flight still fit.
            r_pageFull <= (r_count >= c_PF_LEVEL);
        end
    end

    assign w_flushDone = r_flushWait && w_packerEmpty && !w_wrPending &&
                         (r_state != ST_WR_CMD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flushWait <= 1'b0;
        end else if (bus.flush) begin
            r_flushWait <= 1'b1;
        end else if (w_flushDone) begin
            r_flushWait <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_lastWrite <= 1'b0;
            r_rdAddr    <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE && w_nextState == ST_WR_CMD) begin
                r_lastWrite <= 1'b1;
            end
            if (r_state == ST_IDLE && w_nextState == ST_RD_CMD) begin
                r_lastWrite <= 1'b0;
                r_rdAddr    <= bus.read_sample_address;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_count >= c_URGENT) begin
                    w_nextState = ST_WR_CMD;
                end else if (w_wrPending && bus.read_req) begin
                    w_nextState = r_lastWrite ? ST_RD_CMD : ST_WR_CMD;
                end else if (w_wrPending) begin
                    w_nextState = ST_WR_CMD;
                end else if (bus.read_req) begin
                    w_nextState = ST_RD_CMD;
                end
            end
            ST_WR_CMD: if (bus.mem_cmd_ready) w_nextState = ST_IDLE;
            ST_RD_CMD: if (bus.mem_cmd_ready) w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Command fields come straight from the state register so an asynchronous
    // reset clears them without waiting for a clock.
    always_comb begin
        bus.mem_cmd_valid = 1'b0;
        bus.mem_cmd_write = 1'b0;
        bus.mem_cmd_addr  = '0;
        bus.mem_wdata     = '0;
        bus.mem_wmask     = '0;
        bus.read_allowed  = 1'b0;
        case (r_state)
            ST_WR_CMD: begin
                bus.mem_cmd_valid = 1'b1;
                bus.mem_cmd_write = 1'b1;
                bus.mem_cmd_addr  = w_head.addr;
                bus.mem_wdata     = w_head.data;
                bus.mem_wmask     = w_head.mask;
            end
            ST_RD_CMD: begin
                bus.mem_cmd_valid = 1'b1;
                bus.mem_cmd_addr  = r_rdAddr;
                bus.read_allowed  = bus.mem_cmd_ready;
            end
            default: ;
        endcase
    end

    assign bus.page_full  = r_pageFull;
    assign bus.overflow   = r_overflow;
    assign bus.flush_done = w_flushDone;

endmodule
`default_nettype wire

// File: tb/tb_capture_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_capture_mem_arbiter - directed scoreboard bench for the arbiter
// Rev    : 1.0
// ============================================================================
module tb_capture_mem_arbiter;
    import capture_mem_pkg::*;

    typedef struct packed {
        logic  wr;
        line_t line;
    } exp_t;

    logic   clk     = 1'b0;
    logic   reset_n = 1'b0;
    int     checks  = 0;
    int     errors  = 0;
    exp_t   sb[$];

    capture_mem_arbiter_if bus();

    capture_mem_arbiter #(
        .SAMPLE_PACKET_WIDTH(32),
        .LINE_FIFO_DEPTH    (4),
        .WR_URGENT          (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mkLine(input logic [26:0] addr, input logic [31:0] base);
        exp_t e;
        e           = '0;
        e.wr        = 1'b1;
        e.line.addr = addr;
        e.line.mask = 4'hF;
        for (int s = 0; s < 4; s++) begin
            e.line.data[s*32 +: 32] = base + 32'(s);
        end
        return e;
    endfunction

    function automatic exp_t mkRead(input logic [26:0] addr);
        exp_t e;
        e           = '0;
        e.line.addr = addr;
        return e;
    endfunction

    task automatic drivePkt(input logic [31:0] num, input logic [31:0] val);
        bus.sample_number = num;
        bus.sample_packet = val;
        bus.write_enable  = 1'b1;
        tick();
        bus.write_enable  = 1'b0;
    endtask

    task automatic driveLine(input logic [26:0] addr, input logic [31:0] base);
        for (int s = 0; s < 4; s++) begin
            drivePkt({3'b000, addr, 2'(s)}, base + 32'(s));
        end
    endtask

    // Waits for the next command, compares it to the scoreboard head and
    // lets it be accepted (mem_cmd_ready is expected high).
    task automatic waitCmd(input string tag);
        int   n = 0;
        exp_t e;
        while (bus.mem_cmd_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, bus.mem_cmd_valid, 1'b1);
        if (bus.mem_cmd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check({tag, "_unexpected"}, bus.mem_cmd_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                if (e.wr) begin
                    check({tag, "_wr"},
                          {bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_wmask, bus.mem_wdata},
                          {1'b1, e.line.addr, e.line.mask, e.line.data});
                end else begin
                    check({tag, "_rd"}, {bus.mem_cmd_write, bus.mem_cmd_addr}, {1'b0, e.line.addr});
                end
                check({tag, "_rdallow"}, bus.read_allowed, !e.wr);
                tick();
                check({tag, "_gap"}, {bus.mem_cmd_valid, bus.read_allowed}, 2'b00);
                if (!e.wr) bus.read_req = 1'b0;
            end
        end
    endtask

    initial begin
        bus.sample_packet       = '0;
        bus.write_enable        = 1'b0;
        bus.sample_number       = '0;
        bus.flush               = 1'b0;
        bus.read_req            = 1'b0;
        bus.read_sample_address = '0;
        bus.mem_cmd_ready       = 1'b0;

        repeat (3) tick();
        check("rst_cmd", {bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_wmask, bus.mem_wdata}, '0);
        check("rst_flags", {bus.page_full, bus.flush_done, bus.overflow, bus.read_allowed}, 4'b0000);
        reset_n = 1'b1;
        tick();

        // Full line 0, write latency from the 4th packet
        bus.mem_cmd_ready = 1'b1;
        sb.push_back(mkLine(27'd0, 32'hA0));
        driveLine(27'd0, 32'hA0);
        check("lat_t0", bus.mem_cmd_valid, 1'b0);
        tick();
        check("lat_t1", bus.mem_cmd_valid, 1'b0);
        tick();
        check("lat_t2", bus.mem_cmd_valid, 1'b1);
        waitCmd("line0");
        check("no_flush_done", bus.flush_done, 1'b0);

        // Partial line 1 pushed by flush
        begin
            exp_t e;
            e = '0;
            e.wr = 1'b1;
            e.line.addr = 27'd1;
            e.line.mask = 4'h6;
            e.line.data = 128'h00000000_000000B6_000000B5_00000000;
            sb.push_back(e);
        end
        drivePkt(32'd5, 32'hB5);
        drivePkt(32'd6, 32'hB6);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        waitCmd("flush_line");
        for (int i = 0; i < 4 && bus.flush_done !== 1'b1; i++) tick();
        check("flush_done_hi", bus.flush_done, 1'b1);
        tick();
        check("flush_done_lo", bus.flush_done, 1'b0);

        // Stalled memory: page_full, then overflow on the fifth line
        bus.mem_cmd_ready = 1'b0;
        for (int a = 2; a <= 5; a++) sb.push_back(mkLine(27'(a), 32'hC000_0000 + 32'(a*16)));
        driveLine(27'd2, 32'hC000_0020);
        driveLine(27'd3, 32'hC000_0030);
        repeat (3) tick();
        check("pf_cnt2", bus.page_full, 1'b0);
        driveLine(27'd4, 32'hC000_0040);
        repeat (3) tick();
        check("pf_cnt3", {bus.page_full, bus.overflow}, 2'b10);
        driveLine(27'd5, 32'hC000_0050);
        repeat (3) tick();
        check("ovf_cnt4", bus.overflow, 1'b0);
        driveLine(27'd6, 32'hC000_0060);
        repeat (3) tick();
        check("ovf_set", bus.overflow, 1'b1);
        bus.mem_cmd_ready = 1'b1;
        waitCmd("drain2");
        waitCmd("drain3");
        waitCmd("drain4");
        waitCmd("drain5");
        repeat (3) tick();
        check("ovf_sticky", {bus.overflow, bus.page_full}, 2'b10);

        // Lone read: valid one cycle after read_req
        bus.read_sample_address = 27'h055;
        bus.read_req = 1'b1;
        sb.push_back(mkRead(27'h055));
        tick();
        check("rd_lat", {bus.mem_cmd_valid, bus.mem_cmd_write}, 2'b10);
        waitCmd("rd_lone");

        // Contested grant with one line pending: write first, then read
        sb.push_back(mkLine(27'd7, 32'hD0));
        sb.push_back(mkRead(27'h123));
        driveLine(27'd7, 32'hD0);
        tick();
        bus.read_sample_address = 27'h123;
        bus.read_req = 1'b1;
        waitCmd("rr_wr");
        waitCmd("rr_rd");

        // Urgent writes beat a held read until occupancy falls below 2
        bus.mem_cmd_ready = 1'b0;
        sb.push_back(mkLine(27'd8, 32'hE080));
        sb.push_back(mkLine(27'd9, 32'hE090));
        sb.push_back(mkRead(27'h0AB));
        sb.push_back(mkLine(27'd10, 32'hE0A0));
        driveLine(27'd8, 32'hE080);
        driveLine(27'd9, 32'hE090);
        driveLine(27'd10, 32'hE0A0);
        repeat (3) tick();
        bus.read_sample_address = 27'h0AB;
        bus.read_req = 1'b1;
        bus.mem_cmd_ready = 1'b1;
        waitCmd("urg_w8");
        waitCmd("urg_w9");
        waitCmd("urg_rd");
        waitCmd("urg_w10");

        // Reset while a write command is waiting
        bus.mem_cmd_ready = 1'b0;
        driveLine(27'd11, 32'hF0);
        repeat (3) tick();
        check("pre_rst_valid", bus.mem_cmd_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cmd", {bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_wmask, bus.mem_wdata}, '0);
        check("mid_rst_flags", {bus.page_full, bus.flush_done, bus.overflow, bus.read_allowed}, 4'b0000);
        repeat (2) tick();
        reset_n = 1'b1;
        bus.mem_cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_empty", bus.mem_cmd_valid, 1'b0);
        end
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
